// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and word type for the FIFO read-side drain stage.
package fifo_rd_stream_pkg;

    localparam int FIFO_WIDTH_DFLT = 16;
    localparam int BUF_DEPTH       = 2;

    typedef logic [FIFO_WIDTH_DFLT-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered holding buffer between the FIFO read port and the output stream.
module fifo_rd_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Push and pop together leave the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: issues rd_en, captures data_out a cycle later, presents valid/ready.
// Optional underflow counter is built only when FIFO_RD_ERR_CNT_EN is defined.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_fifo_empty,
    input  logic [FIFO_WIDTH-1:0] i_fifo_data_out,
    input  logic                  i_fifo_underflow,
    output logic                  o_fifo_rd_en,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [FIFO_WIDTH-1:0] o_m_data,
    output logic [31:0]           o_beat_cnt,
    output logic [15:0]           o_err_cnt
);

    logic        r_inflight;
    logic [31:0] r_beat_cnt;
    logic [1:0]  w_count;
    logic        w_pop;
    logic [2:0]  w_occ;

    fifo_rd_skid #(.W(FIFO_WIDTH)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_data_out),
        .i_pop       (w_pop),
        .o_head_data (o_m_data),
        .o_count     (w_count)
    );

    assign o_m_valid = (w_count != 2'd0);
    assign w_pop     = o_m_valid && i_m_ready;

    // Occupancy after this edge, counting the word already requested; a same-cycle pop frees a slot.
    assign w_occ        = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign o_fifo_rd_en = !rst && i_en && !i_fifo_empty && (w_occ < 3'(BUF_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_beat_cnt <= 32'd0;
        end else begin
            r_inflight <= o_fifo_rd_en;
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    assign o_beat_cnt = r_beat_cnt;

`ifdef FIFO_RD_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (i_fifo_underflow && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    logic w_unused_underflow;
    assign w_unused_underflow = i_fifo_underflow;
    assign o_err_cnt          = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO environment, outstanding-word scoreboard, directed tests.
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    fifo_word_t  fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    fifo_word_t  m_data;
    logic [31:0] beat_cnt;
    logic [15:0] err_cnt;

    fifo_rd_stream dut (
        .clk              (clk),
        .rst              (rst),
        .i_en             (en),
        .i_fifo_empty     (fifo_empty),
        .i_fifo_data_out  (fifo_data_out),
        .i_fifo_underflow (fifo_underflow),
        .o_fifo_rd_en     (fifo_rd_en),
        .o_m_valid        (m_valid),
        .i_m_ready        (m_ready),
        .o_m_data         (m_data),
        .o_beat_cnt       (beat_cnt),
        .o_err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fifo_word_t fifo_q[$];   // contents of the upstream FIFO
    fifo_word_t m_q[$];      // words read from the FIFO and not yet delivered, in order
    fifo_word_t dlog[$];     // words the DUT actually delivered
    int         dcyc[$];     // cycle index of each delivery
    bit         rd_last;
    bit         exp_rd;
    bit         exp_pop;
    bit         s_rd;
    bit         s_under;
    int         beats;
    logic [15:0] errs;
    int         rd_pulses = 0;
    int         cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are checked mid-cycle, with inputs stable.
    always @(negedge clk) begin : cmp
        int occ;
        int vis;
        cyc++;
        if (rst) begin
            m_q.delete();
            rd_last = 1'b0;
            beats   = 0;
            errs    = 16'd0;
            exp_rd  = 1'b0;
            exp_pop = 1'b0;
            s_rd    = 1'b0;
            s_under = 1'b0;
            chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_beat_cnt", beat_cnt, 32'd0);
        end else begin
            occ     = m_q.size();
            vis     = occ - int'(rd_last);
            exp_pop = (vis > 0) && m_ready;
            exp_rd  = en && !fifo_empty && ((occ - (exp_pop ? 1 : 0)) < 2);
            chk("m_valid", {31'd0, m_valid}, {31'd0, (vis > 0)});
            if (vis > 0) chk("m_data", {16'd0, m_data}, {16'd0, m_q[0]});
            chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
            chk("beat_cnt", beat_cnt, beats);
`ifdef FIFO_RD_ERR_CNT_EN
            chk("err_cnt", {16'd0, err_cnt}, {16'd0, errs});
`else
            chk("err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
            if (fifo_rd_en) rd_pulses++;
            if (m_valid && m_ready) begin
                dlog.push_back(m_data);
                dcyc.push_back(cyc);
            end
            s_rd    = fifo_rd_en;
            s_under = fifo_underflow;
        end
    end

    // FIFO environment and scoreboard update, just after each rising edge.
    always begin : upd
        fifo_word_t w;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            rd_last = 1'b0;
            beats   = 0;
            errs    = 16'd0;
        end else begin
            if (exp_pop && m_q.size() > 0) begin
                w = m_q.pop_front();
                beats++;
            end
            if (s_rd && fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                fifo_data_out = w;
                if (exp_rd) m_q.push_back(w);
            end
            rd_last = exp_rd && s_rd;
            if (s_under && errs != 16'hFFFF) errs++;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) fifo_q.push_back(fifo_word_t'(base + i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic wait_dlog(input int n, input int budget, input string name);
        int k = 0;
        while (dlog.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, {31'd0, (dlog.size() >= n)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        rst            = 1'b1;
        en             = 1'b0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;
        fifo_empty     = 1'b1;
        fifo_data_out  = '0;
        repeat (2) step();
        chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_m_data", {16'd0, m_data}, 32'd0);
        chk("reset_beat_cnt", beat_cnt, 32'd0);
        chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        step();

        // Streaming: 8 preloaded words at full rate.
        load(8, 1);
        dlog.delete();
        dcyc.delete();
        p0      = rd_pulses;
        en      = 1'b1;
        m_ready = 1'b1;
        wait_dlog(8, 30, "stream_timeout");
        repeat (2) step();
        chk("stream_rd_pulses", rd_pulses - p0, 32'd8);
        for (int i = 0; i < 8; i++) chk("stream_data", {16'd0, dlog[i]}, i + 1);
        chk("stream_back_to_back", dcyc[7] - dcyc[0], 32'd7);
        chk("stream_beat_cnt", beat_cnt, 32'd8);
        chk("stream_rd_en_empty", {31'd0, fifo_rd_en}, 32'd0);

        // Stall: consumer blocks for 10 cycles.
        m_ready = 1'b0;
        load(4, 'h11);
        dlog.delete();
        p0 = rd_pulses;
        repeat (10) step();
        chk("stall_rd_pulses", rd_pulses - p0, 32'd2);
        chk("stall_m_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_m_data", {16'd0, m_data}, 32'h11);
        chk("stall_no_delivery", dlog.size(), 32'd0);
        m_ready = 1'b1;
        wait_dlog(4, 20, "stall_timeout");
        repeat (2) step();
        chk("stall_count", dlog.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk("stall_data", {16'd0, dlog[i]}, 'h11 + i);
        chk("stall_beat_cnt", beat_cnt, 32'd12);

        // Empty guard: no reads while the FIFO is empty.
        p0 = rd_pulses;
        for (int i = 0; i < 20; i++) begin
            en      = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("empty_rd_pulses", rd_pulses - p0, 32'd0);
        chk("empty_m_valid", {31'd0, m_valid}, 32'd0);
        chk("empty_err_cnt", {16'd0, err_cnt}, 32'd0);

        // en drop right after a read: the in-flight word still arrives.
        en      = 1'b0;
        m_ready = 1'b1;
        load(4, 'h21);
        dlog.delete();
        p0 = rd_pulses;
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (5) step();
        chk("endrop_rd_pulses", rd_pulses - p0, 32'd1);
        chk("endrop_count", dlog.size(), 32'd1);
        chk("endrop_data", {16'd0, dlog[0]}, 32'h21);
        chk("endrop_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        en = 1'b1;
        wait_dlog(4, 20, "endrop_timeout");
        for (int i = 1; i < 4; i++) chk("endrop_resume", {16'd0, dlog[i]}, 'h21 + i);
        chk("endrop_beat_cnt", beat_cnt, 32'd16);

        // Reset with one word buffered and one in flight.
        m_ready = 1'b0;
        en      = 1'b1;
        load(4, 'h31);
        step();
        step();
        chk("midrst_pre_valid", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid_async", {31'd0, m_valid}, 32'd0);
        chk("midrst_beat_cnt_async", beat_cnt, 32'd0);
        step();
        rst     = 1'b0;
        m_ready = 1'b1;
        dlog.delete();
        wait_dlog(2, 20, "midrst_timeout");
        chk("midrst_resume0", {16'd0, dlog[0]}, 32'h33);
        chk("midrst_resume1", {16'd0, dlog[1]}, 32'h34);
        repeat (3) step();

        // Underflow pulses for 3 cycles.
        fifo_underflow = 1'b1;
        repeat (3) step();
        fifo_underflow = 1'b0;
        step();
`ifdef FIFO_RD_ERR_CNT_EN
        chk("underflow_err_cnt", {16'd0, err_cnt}, 32'd3);
`else
        chk("underflow_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
